// File: rtl/key_event_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, frames bytes,
// and decodes make/break scan-code sequences into a held-key bitmap.
module key_event_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         ready,
    output logic         keydown
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    function automatic logic is_ignored(input logic [7:0] b);
        logic r;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_s, data_s;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    logic          bit_q, bit_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ferr_q, ferr_d;
    state_t        state_q, state_d;
    logic          make_s, brk_s;
    logic [8:0]    code_s;
    logic [511:0]  key_down_q, key_down_d;
    logic [8:0]    last_change_q;
    logic          ready_q, keydown_q;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronizers; idle PS/2 lines rest high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Filter: accept a new ps2_clk level after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = {FW{1'b0}};
        fall_d = 1'b0;
        bit_d  = bit_q;
        if (clk_s != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_s;
                fall_d = filt_q;
                bit_d  = filt_q ? data_s : bit_q;
            end else begin
                fcnt_d = fcnt_q + {{(FW-1){1'b0}}, 1'b1};
            end
        end else begin
            fcnt_d = {FW{1'b0}};
        end
    end

    // Filter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= {FW{1'b0}};
            fall_q <= 1'b0;
            bit_q  <= 1'b1;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
            bit_q  <= bit_d;
        end
    end

    // Frame receiver: start, 8 data LSB-first, odd parity, stop; idle timeout drops partials
    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        if (fall_q) begin
            tmo_d = {TW{1'b0}};
            case (bitcnt_q)
                4'd0: begin
                    if (!bit_q) begin
                        bitcnt_d = 4'd1;
                    end else begin
                        bitcnt_d = 4'd0;
                    end
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    shift_d  = {bit_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                end
                4'd9: begin
                    par_d    = bit_q;
                    bitcnt_d = 4'd10;
                end
                4'd10: begin
                    bitcnt_d = 4'd0;
                    if (bit_q && odd_parity_ok(shift_q, par_q)) begin
                        byte_vld_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: bitcnt_d = 4'd0;
            endcase
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == TMO_LAST) begin
                bitcnt_d = 4'd0;
                tmo_d    = {TW{1'b0}};
            end else begin
                tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // Frame receiver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= {TW{1'b0}};
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoder next state; a rejected frame abandons any pending prefix
    always_comb begin
        state_d = state_q;
        if (ferr_q) begin
            state_d = S_IDLE;
        end else if (byte_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (shift_q == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (shift_q == 8'hF0) begin
                        state_d = S_BRK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (shift_q == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (shift_q == 8'hE0) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BRK:     state_d = S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder outputs: classify the strobed byte as make, break or nothing
    always_comb begin
        make_s = 1'b0;
        brk_s  = 1'b0;
        code_s = {1'b0, shift_q};
        if (byte_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (shift_q != 8'hE0 && shift_q != 8'hF0 && !is_ignored(shift_q)) begin
                        make_s = 1'b1;
                    end else begin
                        make_s = 1'b0;
                    end
                end
                S_EXT: begin
                    code_s = {1'b1, shift_q};
                    if (shift_q != 8'hE0 && shift_q != 8'hF0) begin
                        make_s = 1'b1;
                    end else begin
                        make_s = 1'b0;
                    end
                end
                S_BRK: brk_s = 1'b1;
                S_EXT_BRK: begin
                    brk_s  = 1'b1;
                    code_s = {1'b1, shift_q};
                end
                default: make_s = 1'b0;
            endcase
        end else begin
            make_s = 1'b0;
        end
    end

    // Held-key bitmap update
    always_comb begin
        key_down_d = key_down_q;
        if (make_s) begin
            key_down_d[code_s] = 1'b1;
        end else if (brk_s) begin
            key_down_d[code_s] = 1'b0;
        end else begin
            key_down_d = key_down_q;
        end
    end

    // Registered user-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_down_q    <= 512'd0;
            last_change_q <= 9'h000;
            ready_q       <= 1'b0;
            keydown_q     <= 1'b0;
        end else begin
            key_down_q <= key_down_d;
            keydown_q  <= |key_down_d;
            ready_q    <= make_s | brk_s;
            if (make_s || brk_s) begin
                last_change_q <= code_s;
            end else begin
                last_change_q <= last_change_q;
            end
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign ready       = ready_q;
    assign keydown     = keydown_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized bench for key_event_decoder against a prefix-accumulator reference model.
module tb_key_event_decoder;

    localparam int FL   = 4;
    localparam int TMO  = 200;
    localparam int HALF = 20;
    localparam int GAP  = 30;

    logic         clk;
    logic         rst;
    logic         ps2_clk;
    logic         ps2_data;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         ready;
    logic         keydown;

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt = 0;
    bit ready_prev = 1'b0;

    logic [511:0] m_kd;
    logic [8:0]   m_lc;
    bit           m_ext, m_brk;

    key_event_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_down(key_down), .last_change(last_change), .ready(ready), .keydown(keydown)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ready monitor: count pulses and require a gap between them
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            ready_cnt++;
            chk("ready_back_to_back", ready_prev, 1'b0);
        end
        ready_prev = (ready === 1'b1);
    end

    // Reference decoder: prefixes accumulate until a code byte completes the event
    task automatic model_byte(input logic [7:0] b, output int pulses);
        logic [8:0] code;
        pulses = 0;
        code = {m_ext, b};
        if (m_brk) begin
            m_kd[code] = 1'b0;
            m_lc = code;
            pulses = 1;
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (!m_ext && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                                b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
            pulses = 0;
        end else begin
            m_kd[code] = 1'b1;
            m_lc = code;
            pulses = 1;
            m_ext = 0;
        end
    endtask

    task automatic model_reset();
        m_kd = '0; m_lc = 9'h000; m_ext = 0; m_brk = 0;
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge clk) ps2_data = v;
        if ($urandom_range(0, 3) == 0) begin
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FL - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 4 - (FL - 2)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        @(negedge clk) ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_last_change"}, last_change, m_lc);
        chk({tag, "_key_down"}, key_down, m_kd);
        chk({tag, "_keydown"}, keydown, |m_kd);
    endtask

    // kind: 0 good, 1 even parity, 2 stop bit 0
    task automatic do_frame(input logic [7:0] b, input int kind);
        int r0, p;
        r0 = ready_cnt;
        send_frame(b, 11, kind == 1, kind == 2);
        p = 0;
        if (kind == 0) model_byte(b, p);
        else begin m_ext = 0; m_brk = 0; end
        chk("ready_pulses", ready_cnt - r0, p);
        check_outputs("frame");
    endtask

    task automatic do_partial(input logic [7:0] b, input int nbits);
        int r0;
        r0 = ready_cnt;
        send_frame(b, nbits, 0, 0);
        repeat (TMO + 50) @(negedge clk);
        chk("partial_ready_pulses", ready_cnt - r0, 0);
        check_outputs("partial");
    endtask

    logic [7:0] pool [8];
    logic [7:0] ign  [6];

    initial begin
        logic [7:0] b;
        int r, k;
        pool = '{8'h16, 8'h1E, 8'h26, 8'h75, 8'h15, 8'hA5, 8'h6B, 8'h29};
        ign  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", ready, 1'b0);
        check_outputs("reset");

        do_frame(8'h16, 0);
        chk("make16_lc", last_change, 9'h016);
        chk("make16_bit", key_down[9'h016], 1'b1);
        do_frame(8'hF0, 0);
        do_frame(8'h16, 0);
        chk("break16_bit", key_down[9'h016], 1'b0);
        chk("break16_keydown", keydown, 1'b0);

        do_frame(8'hE0, 0);
        do_frame(8'h75, 0);
        chk("ext_make_lc", last_change, 9'h175);
        chk("ext_make_bit075", key_down[9'h075], 1'b0);
        do_frame(8'hE0, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h75, 0);
        chk("ext_break_bit175", key_down[9'h175], 1'b0);

        do_frame(8'h1E, 1);
        do_frame(8'h1E, 0);
        chk("after_bad_parity_lc", last_change, 9'h01E);

        do_partial(8'h55, 5);
        do_frame(8'h26, 0);
        chk("after_timeout_lc", last_change, 9'h026);

        do_frame(8'h16, 0);
        do_frame(8'h1E, 0);
        send_frame(8'h33, 4, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
        chk("midframe_rst_ready", ready, 1'b0);
        check_outputs("midframe_rst");
        do_frame(8'h26, 0);

        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = 8'hE0;
            else if (r < 38) b = 8'hF0;
            else if (r < 46) b = ign[$urandom_range(0, 5)];
            else             b = pool[$urandom_range(0, 7)];
            k = $urandom_range(0, 99);
            if (k < 6)       do_frame(b, 1);
            else if (k < 10) do_frame(b, 2);
            else if (k < 14) do_partial(b, $urandom_range(1, 10));
            else             do_frame(b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
